// File: rtl/playlist_sequencer.sv
// Playlist controller: sequences a song index over NUM_SONGS tracks with play/pause/stop/next/prev/select,
// playback modes, auto-advance on song completion and an elapsed-play counter. IDX_W must not exceed 8.
module playlist_sequencer #(
  parameter int NUM_SONGS        = 10,
  parameter int IDX_W            = 4,
  parameter int CNT_W            = 24,
  parameter int PREV_RESTART_CYC = 1000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  input  logic [IDX_W-1:0] sel_index,
  input  logic [1:0]       mode,
  input  logic             song_done,
  output logic             ld,
  output logic             p,
  output logic             ps,
  output logic             pn,
  output logic             pp,
  output logic             sl,
  output logic [IDX_W-1:0] song_index,
  output logic             restart,
  output logic             end_of_list,
  output logic [CNT_W-1:0] elapsed
);

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_PLAY   = 3'd1;
  localparam logic [2:0] CMD_PAUSE  = 3'd2;
  localparam logic [2:0] CMD_NEXT   = 3'd3;
  localparam logic [2:0] CMD_PREV   = 3'd4;
  localparam logic [2:0] CMD_SELECT = 3'd5;

  localparam logic [1:0] MODE_SEQ  = 2'b00;
  localparam logic [1:0] MODE_RALL = 2'b01;
  localparam logic [1:0] MODE_RONE = 2'b10;
  localparam logic [1:0] MODE_SHUF = 2'b11;

  localparam logic [IDX_W:0]   NSONGS     = (IDX_W+1)'(NUM_SONGS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SONGS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] RESTART_TH = CNT_W'(PREV_RESTART_CYC);

  // One-hot encoding so every strobe is a flop output.
  typedef enum logic [5:0] {
    S_LOAD   = 6'b000001,
    S_PLAY   = 6'b000010,
    S_PAUSE  = 6'b000100,
    S_NEXT   = 6'b001000,
    S_PREV   = 6'b010000,
    S_SELECT = 6'b100000
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] index_r, index_nxt_s;
  logic [CNT_W-1:0] elapsed_r;
  logic [7:0]       lfsr_r;
  logic             restart_r, restart_nxt_s;
  logic             eol_r, eol_nxt_s;
  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] shuffle_pick_s;
  logic [IDX_W-1:0] next_pick_s;
  logic             sel_ok_s;
  logic             clear_s;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    if (i == LAST_IDX) idx_inc = IDX_ZERO;
    else               idx_inc = i + IDX_ONE;
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec(input logic [IDX_W-1:0] i);
    if (i == IDX_ZERO) idx_dec = LAST_IDX;
    else               idx_dec = i - IDX_ONE;
  endfunction

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    lfsr_step = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Shuffle candidate folded into range, never equal to the current track
  always_comb begin
    cand_s = {1'b0, lfsr_r[IDX_W-1:0]};
    if (cand_s >= NSONGS) cand_s = cand_s - NSONGS;
    else                  cand_s = cand_s;
    if (cand_s[IDX_W-1:0] == index_r) shuffle_pick_s = idx_inc(index_r);
    else                              shuffle_pick_s = cand_s[IDX_W-1:0];
    if (mode == MODE_SHUF) next_pick_s = shuffle_pick_s;
    else                   next_pick_s = idx_inc(index_r);
    sel_ok_s = ({1'b0, sel_index} < NSONGS);
  end

  // Next-state, next-index and pulse decisions
  always_comb begin
    state_nxt_s   = state_r;
    index_nxt_s   = index_r;
    restart_nxt_s = 1'b0;
    eol_nxt_s     = 1'b0;
    case (state_r)
      S_LOAD: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_PLAY: state_nxt_s = S_PLAY;
            CMD_SELECT: begin
              if (sel_ok_s) begin
                state_nxt_s = S_SELECT;
                index_nxt_s = sel_index;
              end else begin
                state_nxt_s = state_r;
              end
            end
            default: state_nxt_s = state_r;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_PLAY: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_STOP:  state_nxt_s = S_LOAD;
            CMD_PLAY:  state_nxt_s = S_PLAY;
            CMD_PAUSE: state_nxt_s = S_PAUSE;
            CMD_NEXT: begin
              state_nxt_s = S_NEXT;
              index_nxt_s = next_pick_s;
            end
            CMD_PREV: begin
              state_nxt_s = S_PREV;
              if (elapsed_r >= RESTART_TH) restart_nxt_s = 1'b1;
              else                         index_nxt_s   = idx_dec(index_r);
            end
            CMD_SELECT: begin
              if (sel_ok_s) begin
                state_nxt_s = S_SELECT;
                index_nxt_s = sel_index;
              end else begin
                state_nxt_s = state_r;
              end
            end
            default: state_nxt_s = state_r;
          endcase
        end else if (song_done) begin
          case (mode)
            MODE_SEQ: begin
              if (index_r == LAST_IDX) begin
                state_nxt_s = S_LOAD;
                index_nxt_s = IDX_ZERO;
                eol_nxt_s   = 1'b1;
              end else begin
                state_nxt_s = S_NEXT;
                index_nxt_s = idx_inc(index_r);
              end
            end
            MODE_RALL: begin
              state_nxt_s = S_NEXT;
              index_nxt_s = idx_inc(index_r);
            end
            MODE_RONE: restart_nxt_s = 1'b1;
            MODE_SHUF: begin
              state_nxt_s = S_NEXT;
              index_nxt_s = shuffle_pick_s;
            end
            default: state_nxt_s = state_r;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_PAUSE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_PLAY: state_nxt_s = S_PLAY;
            CMD_STOP: state_nxt_s = S_LOAD;
            CMD_SELECT: begin
              if (sel_ok_s) begin
                state_nxt_s = S_SELECT;
                index_nxt_s = sel_index;
              end else begin
                state_nxt_s = state_r;
              end
            end
            default: state_nxt_s = state_r;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_NEXT, S_PREV, S_SELECT: state_nxt_s = S_PLAY;
      default: state_nxt_s = S_LOAD;
    endcase
  end

  // Counter clears on entry to any non-playing transfer state or on a rewind
  always_comb begin
    case (state_nxt_s)
      S_LOAD, S_NEXT, S_PREV, S_SELECT: clear_s = 1'b1;
      default:                          clear_s = restart_nxt_s;
    endcase
  end

  // State, index, pulses and shuffle LFSR
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r   <= S_LOAD;
      index_r   <= IDX_ZERO;
      restart_r <= 1'b0;
      eol_r     <= 1'b0;
      lfsr_r    <= 8'h01;
    end else begin
      state_r   <= state_nxt_s;
      index_r   <= index_nxt_s;
      restart_r <= restart_nxt_s;
      eol_r     <= eol_nxt_s;
      lfsr_r    <= lfsr_step(lfsr_r);
    end
  end

  // Saturating elapsed-play counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      elapsed_r <= CNT_ZERO;
    end else if (clear_s) begin
      elapsed_r <= CNT_ZERO;
    end else if ((state_r == S_PLAY) && (elapsed_r != CNT_MAX)) begin
      elapsed_r <= elapsed_r + CNT_ONE;
    end else begin
      elapsed_r <= elapsed_r;
    end
  end

  assign ld          = state_r[0];
  assign p           = state_r[1];
  assign ps          = state_r[2];
  assign pn          = state_r[3];
  assign pp          = state_r[4];
  assign sl          = state_r[5];
  assign song_index  = index_r;
  assign restart     = restart_r;
  assign end_of_list = eol_r;
  assign elapsed     = elapsed_r;

endmodule

// File: tb/tb_playlist_sequencer.sv
// Directed, table-driven bench for playlist_sequencer (NUM_SONGS=10, IDX_W=4) plus multi-cycle sequences.
module tb_playlist_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [3:0]  sel_index;
  logic [1:0]  mode;
  logic        song_done;
  logic        ld, p, ps, pn, pp, sl;
  logic [3:0]  song_index;
  logic        restart, end_of_list;
  logic [23:0] elapsed;

  localparam logic [2:0] C_STOP = 3'd0, C_PLAY = 3'd1, C_PAUSE = 3'd2,
                         C_NEXT = 3'd3, C_PREV = 3'd4, C_SEL = 3'd5, C_BAD = 3'd6;
  // Strobe order {sl, pp, pn, ps, p, ld}
  localparam logic [5:0] ST_LD = 6'b000001, ST_P = 6'b000010, ST_PS = 6'b000100,
                         ST_PN = 6'b001000, ST_PP = 6'b010000, ST_SL = 6'b100000;

  playlist_sequencer dut (
    .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd(cmd),
    .sel_index(sel_index), .mode(mode), .song_done(song_done),
    .ld(ld), .p(p), .ps(ps), .pn(pn), .pp(pp), .sl(sl),
    .song_index(song_index), .restart(restart), .end_of_list(end_of_list),
    .elapsed(elapsed)
  );

  always #5 Clock = ~Clock;

  wire [11:0] obs = {sl, pp, pn, ps, p, ld, song_index, restart, end_of_list};

  // Reference LFSR, x^8+x^6+x^5+x^4+1 from seed 8'h01
  logic [7:0] lfsr_m;
  always @(posedge Clock) begin
    if (Reset) lfsr_m <= 8'h01;
    else       lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic [3:0] sel;
    logic [1:0] m;
    logic       sd;
    logic [5:0] strb;
    logic [3:0] idx;
    logic       rst;
    logic       eol;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] c, input logic [3:0] sel, input logic [1:0] m,
                     input logic sd, input logic [5:0] strb, input logic [3:0] idx,
                     input logic rst, input logic eol);
    vec_t e;
    e.v = v; e.c = c; e.sel = sel; e.m = m; e.sd = sd;
    e.strb = strb; e.idx = idx; e.rst = rst; e.eol = eol;
    tbl.push_back(e);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic sd);
    cmd_valid = v; cmd = c; song_done = sd;
    step();
  endtask

  task automatic idle();
    drive(1'b0, C_STOP, 1'b0);
  endtask

  function automatic logic [11:0] ex(input logic [5:0] s, input logic [3:0] i,
                                     input logic r, input logic e);
    return {s, i, r, e};
  endfunction

  function automatic logic [3:0] inc10(input logic [3:0] i);
    return (i == 4'd9) ? 4'd0 : i + 4'd1;
  endfunction

  function automatic logic [3:0] dec10(input logic [3:0] i);
    return (i == 4'd0) ? 4'd9 : i - 4'd1;
  endfunction

  function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] cur);
    logic [4:0] c;
    c = {1'b0, l[3:0]};
    if (c >= 5'd10) c = c - 5'd10;
    if (c[3:0] == cur) return inc10(cur);
    return c[3:0];
  endfunction

  initial begin
    logic [3:0] cur;
    logic [3:0] exp_idx;

    Reset = 1'b1; cmd_valid = 1'b0; cmd = C_STOP; sel_index = 4'd0; mode = 2'b00; song_done = 1'b0;

    // Vector table: {valid, cmd, sel, mode, song_done} -> {strobes, index, restart, end_of_list}
    add(1'b1, C_PLAY, 4'd0, 2'b00, 1'b0, ST_P, 4'd0, 1'b0, 1'b0);
    add(1'b0, C_STOP, 4'd0, 2'b00, 1'b0, ST_P, 4'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      add(1'b1, C_NEXT, 4'd0, 2'b00, 1'b0, ST_PN, 4'(k % 10), 1'b0, 1'b0);
      add(1'b0, C_STOP, 4'd0, 2'b00, 1'b0, ST_P,  4'(k % 10), 1'b0, 1'b0);
    end
    add(1'b1, C_SEL,   4'd7,  2'b00, 1'b0, ST_SL, 4'd7, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd7, 1'b0, 1'b0);
    add(1'b1, C_SEL,   4'd12, 2'b00, 1'b0, ST_P,  4'd7, 1'b0, 1'b0);
    add(1'b1, C_BAD,   4'd0,  2'b00, 1'b0, ST_P,  4'd7, 1'b0, 1'b0);
    add(1'b1, C_PAUSE, 4'd0,  2'b00, 1'b0, ST_PS, 4'd7, 1'b0, 1'b0);
    add(1'b1, C_NEXT,  4'd0,  2'b00, 1'b0, ST_PS, 4'd7, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b1, ST_PS, 4'd7, 1'b0, 1'b0);
    add(1'b1, C_PLAY,  4'd0,  2'b00, 1'b0, ST_P,  4'd7, 1'b0, 1'b0);
    add(1'b1, C_STOP,  4'd0,  2'b00, 1'b0, ST_LD, 4'd7, 1'b0, 1'b0);
    add(1'b1, C_NEXT,  4'd0,  2'b00, 1'b0, ST_LD, 4'd7, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b1, ST_LD, 4'd7, 1'b0, 1'b0);
    add(1'b1, C_SEL,   4'd9,  2'b00, 1'b0, ST_SL, 4'd9, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd9, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b1, ST_LD, 4'd0, 1'b0, 1'b1);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_LD, 4'd0, 1'b0, 1'b0);
    add(1'b1, C_PLAY,  4'd0,  2'b00, 1'b0, ST_P,  4'd0, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b1, ST_PN, 4'd1, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd1, 1'b0, 1'b0);
    add(1'b1, C_SEL,   4'd9,  2'b01, 1'b0, ST_SL, 4'd9, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b01, 1'b0, ST_P,  4'd9, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b01, 1'b1, ST_PN, 4'd0, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b01, 1'b0, ST_P,  4'd0, 1'b0, 1'b0);
    add(1'b1, C_SEL,   4'd4,  2'b10, 1'b0, ST_SL, 4'd4, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b10, 1'b0, ST_P,  4'd4, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b10, 1'b1, ST_P,  4'd4, 1'b1, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b10, 1'b0, ST_P,  4'd4, 1'b0, 1'b0);
    add(1'b1, C_NEXT,  4'd0,  2'b00, 1'b1, ST_PN, 4'd5, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd5, 1'b0, 1'b0);
    add(1'b1, C_PREV,  4'd0,  2'b00, 1'b0, ST_PP, 4'd4, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd4, 1'b0, 1'b0);
    add(1'b1, C_SEL,   4'd0,  2'b00, 1'b0, ST_SL, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, C_STOP, 4'd0, 2'b00, 1'b0, ST_P, 4'd0, 1'b0, 1'b0);
    add(1'b1, C_PREV,  4'd0,  2'b00, 1'b0, ST_PP, 4'd9, 1'b0, 1'b0);
    add(1'b0, C_STOP,  4'd0,  2'b00, 1'b0, ST_P,  4'd9, 1'b0, 1'b0);

    step();
    step();
    chk("reset_outputs", 32'(obs), 32'(ex(ST_LD, 4'd0, 1'b0, 1'b0)));
    chk("reset_elapsed", 32'(elapsed), 32'd0);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v; cmd = tbl[i].c; sel_index = tbl[i].sel;
      mode = tbl[i].m; song_done = tbl[i].sd;
      step();
      chk($sformatf("vec%0d", i), 32'(obs),
          32'(ex(tbl[i].strb, tbl[i].idx, tbl[i].rst, tbl[i].eol)));
    end

    // PREV restart threshold: 1200 -> restart, 999 -> previous, 1000 -> restart
    mode = 2'b00;
    chk("el_after_prev", 32'(elapsed), 32'd0);
    repeat (1200) idle();
    chk("el_1200", 32'(elapsed), 32'd1200);
    drive(1'b1, C_PREV, 1'b0);
    chk("prev_restart", 32'(obs), 32'(ex(ST_PP, 4'd9, 1'b1, 1'b0)));
    chk("prev_restart_el", 32'(elapsed), 32'd0);
    idle();
    chk("after_restart", 32'(obs), 32'(ex(ST_P, 4'd9, 1'b0, 1'b0)));
    repeat (999) idle();
    chk("el_999", 32'(elapsed), 32'd999);
    drive(1'b1, C_PREV, 1'b0);
    chk("prev_at_999", 32'(obs), 32'(ex(ST_PP, 4'd8, 1'b0, 1'b0)));
    idle();
    repeat (1000) idle();
    chk("el_1000", 32'(elapsed), 32'd1000);
    drive(1'b1, C_PREV, 1'b0);
    chk("prev_at_1000", 32'(obs), 32'(ex(ST_PP, 4'd8, 1'b1, 1'b0)));
    idle();

    // Pause holds the elapsed counter
    repeat (299) idle();
    chk("el_299", 32'(elapsed), 32'd299);
    drive(1'b1, C_PAUSE, 1'b0);
    chk("pause_enter", 32'(obs), 32'(ex(ST_PS, 4'd8, 1'b0, 1'b0)));
    chk("pause_el", 32'(elapsed), 32'd300);
    for (int k = 0; k < 100; k++) begin
      idle();
      chk("pause_hold", 32'(elapsed), 32'd300);
    end
    drive(1'b0, C_STOP, 1'b1);
    chk("pause_done_ignored", 32'(obs), 32'(ex(ST_PS, 4'd8, 1'b0, 1'b0)));
    drive(1'b1, C_PLAY, 1'b0);
    chk("resume", 32'(obs), 32'(ex(ST_P, 4'd8, 1'b0, 1'b0)));
    chk("resume_el", 32'(elapsed), 32'd300);
    idle();
    chk("resume_el_next", 32'(elapsed), 32'd301);

    // Shuffle auto-advance against the reference LFSR
    mode = 2'b11;
    cur = 4'd8;
    for (int k = 0; k < 50; k++) begin
      exp_idx = pick(lfsr_m, cur);
      drive(1'b0, C_STOP, 1'b1);
      chk($sformatf("shuf%0d", k), 32'(obs), 32'(ex(ST_PN, exp_idx, 1'b0, 1'b0)));
      chk("shuf_range", 32'(song_index < 4'd10), 32'd1);
      chk("shuf_norepeat", 32'(song_index != cur), 32'd1);
      idle();
      cur = exp_idx;
    end
    exp_idx = pick(lfsr_m, cur);
    drive(1'b1, C_NEXT, 1'b0);
    chk("shuf_manual_next", 32'(obs), 32'(ex(ST_PN, exp_idx, 1'b0, 1'b0)));
    cur = exp_idx;
    idle();
    drive(1'b1, C_PREV, 1'b0);
    chk("shuf_prev", 32'(obs), 32'(ex(ST_PP, dec10(cur), 1'b0, 1'b0)));
    cur = dec10(cur);
    idle();

    // Reset asserted while in NEXT
    mode = 2'b00;
    drive(1'b1, C_NEXT, 1'b0);
    chk("next_before_reset", 32'(obs), 32'(ex(ST_PN, inc10(cur), 1'b0, 1'b0)));
    Reset = 1'b1;
    drive(1'b1, C_PLAY, 1'b0);
    chk("reset_in_next", 32'(obs), 32'(ex(ST_LD, 4'd0, 1'b0, 1'b0)));
    chk("reset_in_next_el", 32'(elapsed), 32'd0);
    Reset = 1'b0;
    idle();
    chk("after_reset_load", 32'(obs), 32'(ex(ST_LD, 4'd0, 1'b0, 1'b0)));
    drive(1'b1, C_PLAY, 1'b0);
    mode = 2'b11;
    exp_idx = pick(lfsr_m, 4'd0);
    drive(1'b0, C_STOP, 1'b1);
    chk("shuf_after_reset", 32'(obs), 32'(ex(ST_PN, exp_idx, 1'b0, 1'b0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
